// File: rtl/uart_pkg.sv
// Shared definitions for the button-to-UART scheduler: byte width,
// scheduler state encoding and the ASCII identifier helper.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam logic [7:0] DEFAULT_NEWLINE = 8'h0A;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_ID = 3'd1,
    ACK_ID  = 3'd2,
    DONE_ID = 3'd3,
    SEND_NL = 3'd4,
    ACK_NL  = 3'd5,
    DONE_NL = 3'd6
  } state_t;

  // Identifier byte for a button index; wraps modulo 256
  function automatic logic [7:0] id_char(input logic [7:0] base, input logic [7:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/button_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting just after the
// previous winner and wraps modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  // First requester found at last+1, last+2, ... wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      logic [IW-1:0] j;
      j = IW'((int'(last) + k) % N);
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = j;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/button_tx_scheduler.sv
// Captures debounced button presses as pending requests and serialises
// round-robin grants to a shared UART as ID byte (+ optional newline).
module button_tx_scheduler
  import uart_pkg::*;
#(
  parameter int         NUM_BUTTONS  = 4,
  parameter logic [7:0] BASE_CHAR    = 8'h30,
  parameter bit         SEND_NEWLINE = 1'b1,
  parameter logic [7:0] NEWLINE_CHAR = DEFAULT_NEWLINE
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_BUTTONS-1:0]         switch_debounced,
  input  logic                           tx_busy,
  input  logic                           clear_overrun,
  output logic                           tx_start,
  output logic [BYTE_W-1:0]              tx_data,
  output logic [NUM_BUTTONS-1:0]         pending,
  output logic [$clog2(NUM_BUTTONS)-1:0] grant_id,
  output logic [NUM_BUTTONS-1:0]         overrun
);

  localparam int IW = $clog2(NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0] prev_r;
  logic [NUM_BUTTONS-1:0] rise_s;
  logic [NUM_BUTTONS-1:0] clear_mask_s;
  logic                   gnt_valid_s;
  logic [IW-1:0]          gnt_idx_s;
  logic [IW-1:0]          last_grant_r;
  logic                   grant_fire_s;
  state_t                 state_r;

  rr_arbiter #(.N(NUM_BUTTONS)) u_arb (
    .req       (pending),
    .last      (last_grant_r),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Rising-edge detect and the pending bit cleared by this cycle's grant
  always_comb begin
    rise_s       = switch_debounced & ~prev_r;
    grant_fire_s = (state_r == IDLE) && gnt_valid_s && !tx_busy;
    clear_mask_s = '0;
    if (grant_fire_s) begin
      clear_mask_s[gnt_idx_s] = 1'b1;
    end else begin
      clear_mask_s = '0;
    end
  end

  // Edge history, request queue and sticky overrun; a new press beats a grant clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_r  <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      prev_r  <= switch_debounced;
      pending <= (pending & ~clear_mask_s) | rise_s;
      if (clear_overrun) begin
        overrun <= rise_s & pending & ~clear_mask_s;
      end else begin
        overrun <= overrun | (rise_s & pending & ~clear_mask_s);
      end
    end
  end

  // Transmit sequencer with registered UART handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      last_grant_r <= IW'(NUM_BUTTONS - 1);
    end else begin
      tx_start <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_fire_s) begin
            grant_id     <= gnt_idx_s;
            last_grant_r <= gnt_idx_s;
            tx_data      <= id_char(BASE_CHAR, 8'(gnt_idx_s));
            tx_start     <= 1'b1;
            state_r      <= ACK_ID;
          end else begin
            state_r <= IDLE;
          end
        end
        ACK_ID: begin
          if (tx_busy) state_r <= DONE_ID;
          else         state_r <= ACK_ID;
        end
        DONE_ID: begin
          if (tx_busy)           state_r <= DONE_ID;
          else if (SEND_NEWLINE) state_r <= SEND_NL;
          else                   state_r <= IDLE;
        end
        SEND_NL: begin
          if (!tx_busy) begin
            tx_data  <= NEWLINE_CHAR;
            tx_start <= 1'b1;
            state_r  <= ACK_NL;
          end else begin
            state_r <= SEND_NL;
          end
        end
        ACK_NL: begin
          if (tx_busy) state_r <= DONE_NL;
          else         state_r <= ACK_NL;
        end
        DONE_NL: begin
          if (tx_busy) state_r <= DONE_NL;
          else         state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_tx_scheduler.sv
// Self-checking bench: table of press patterns with hand-derived grant order,
// scoreboard of expected UART bytes, plus multi-cycle corner sequences.
module tb_button_tx_scheduler;
  import uart_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] switch_debounced = 4'd0;
  logic       busy_force = 1'b0;
  logic       clear_overrun = 1'b0;
  logic       tx_busy, tx_start;
  logic [7:0] tx_data;
  logic [3:0] pending, overrun;
  logic [1:0] grant_id;

  logic [3:0] switch2 = 4'd0;
  logic       tx_busy2, tx_start2;
  logic [7:0] tx_data2;
  logic [3:0] pending2, overrun2;
  logic [1:0] grant_id2;

  int checks = 0;
  int failures = 0;
  int start_count = 0;
  int start_count2 = 0;

  typedef struct { logic [7:0] data; logic [1:0] gid; bit chk_gid; } exp_t;
  exp_t sb[$];
  exp_t sb2[$];

  typedef struct { logic [3:0] press; int n; logic [7:0] ids; } vec_t;
  vec_t tbl[6];

  always #5 clock = ~clock;

  button_tx_scheduler dut (
    .clock(clock), .reset(reset), .switch_debounced(switch_debounced),
    .tx_busy(tx_busy), .clear_overrun(clear_overrun), .tx_start(tx_start),
    .tx_data(tx_data), .pending(pending), .grant_id(grant_id), .overrun(overrun)
  );

  button_tx_scheduler #(.SEND_NEWLINE(1'b0)) dut2 (
    .clock(clock), .reset(reset), .switch_debounced(switch2),
    .tx_busy(tx_busy2), .clear_overrun(1'b0), .tx_start(tx_start2),
    .tx_data(tx_data2), .pending(pending2), .grant_id(grant_id2), .overrun(overrun2)
  );

  // UART models: busy rises 2 cycles after tx_start and lasts 20 cycles
  int cnt = 0;
  int cnt2 = 0;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt  <= 0;
      cnt2 <= 0;
    end else begin
      if (tx_start) cnt <= 1;
      else if (cnt != 0 && cnt < 22) cnt <= cnt + 1;
      else cnt <= 0;
      if (tx_start2) cnt2 <= 1;
      else if (cnt2 != 0 && cnt2 < 22) cnt2 <= cnt2 + 1;
      else cnt2 <= 0;
    end
  end
  assign tx_busy  = ((cnt >= 2) && (cnt < 22)) || busy_force;
  assign tx_busy2 = (cnt2 >= 2) && (cnt2 < 22);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitors sample away from the active edge
  logic prev_start = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (reset && tx_start) begin
      start_count++;
      check("start_while_busy", tx_busy, 1'b0);
      check("start_back_to_back", prev_start, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("tx_data", tx_data, e.data);
        if (e.chk_gid) check("grant_id_at_start", grant_id, e.gid);
      end
    end
    prev_start = tx_start;
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset && tx_start2) begin
      start_count2++;
      if (sb2.size() == 0) begin
        check("unexpected_start_nl0", 32'd1, 32'd0);
      end else begin
        e = sb2.pop_front();
        check("tx_data_nl0", tx_data2, e.data);
      end
    end
  end

  task automatic push_frame(input logic [1:0] id);
    sb.push_back('{data: 8'h30 + 8'(id), gid: id, chk_gid: 1'b1});
    sb.push_back('{data: 8'h0A, gid: 2'd0, chk_gid: 1'b0});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || dut.state_r != IDLE) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  function automatic vec_t mk(input logic [3:0] press, input int n,
                              input logic [1:0] i0, input logic [1:0] i1,
                              input logic [1:0] i2, input logic [1:0] i3);
    vec_t v;
    v.press = press;
    v.n = n;
    v.ids = {i3, i2, i1, i0};
    return v;
  endfunction

  initial begin
    int sc;
    logic [1:0] id;
    // Grant order derived by hand from last_grant carried across entries
    tbl[0] = mk(4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0);  // after reset, last=3
    tbl[1] = mk(4'b1000, 1, 2'd3, 2'd0, 2'd0, 2'd0);
    tbl[2] = mk(4'b1011, 3, 2'd0, 2'd1, 2'd3, 2'd0);  // last=3
    tbl[3] = mk(4'b0010, 1, 2'd1, 2'd0, 2'd0, 2'd0);
    tbl[4] = mk(4'b1001, 2, 2'd3, 2'd0, 2'd0, 2'd0);  // last=1: wrap to 3 first
    tbl[5] = mk(4'b1111, 4, 2'd1, 2'd2, 2'd3, 2'd0);  // last=0

    repeat (3) @(posedge clock);
    #1;
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_pending", pending, 4'h0);
    check("rst_overrun", overrun, 4'h0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_last_grant", dut.last_grant_r, 2'd3);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    for (int v = 0; v < 6; v++) begin
      @(posedge clock); #1;
      switch_debounced = tbl[v].press;
      for (int k = 0; k < tbl[v].n; k++) begin
        id = tbl[v].ids[2*k +: 2];
        push_frame(id);
      end
      @(posedge clock); #1;
      check("pending_after_rise", pending, tbl[v].press);
      check("no_early_start", tx_start, 1'b0);
      @(posedge clock); #1;
      check("start_latency", tx_start, 1'b1);
      id = tbl[v].ids[1:0];
      check("pending_cleared", pending, tbl[v].press & ~(4'b0001 << id));
      wait_drain(3000);
      check("pending_drained", pending, 4'h0);
      check("no_overrun", overrun, 4'h0);
      id = tbl[v].ids[2*(tbl[v].n-1) +: 2];
      check("grant_id_hold", grant_id, id);
      switch_debounced = 4'd0;
      repeat (3) @(posedge clock);
    end

    // Second rise of a still-pending button flags overrun and sends one frame
    #1;
    switch_debounced = 4'b0001;
    push_frame(2'd0);
    push_frame(2'd1);
    repeat (4) @(posedge clock); #1;
    switch_debounced = 4'b0011;
    repeat (2) @(posedge clock); #1;
    switch_debounced = 4'b0001;
    repeat (2) @(posedge clock); #1;
    switch_debounced = 4'b0011;
    repeat (2) @(posedge clock); #1;
    check("overrun_set", overrun, 4'b0010);
    check("overrun_pending", pending, 4'b0010);
    wait_drain(3000);
    check("overrun_sticky", overrun, 4'b0010);
    check("overrun_pending_drained", pending, 4'h0);
    clear_overrun = 1'b1;
    @(posedge clock); #1;
    clear_overrun = 1'b0;
    check("overrun_cleared", overrun, 4'h0);
    switch_debounced = 4'd0;
    repeat (3) @(posedge clock); #1;

    // External busy holds off the grant until it drops
    busy_force = 1'b1;
    sc = start_count;
    switch_debounced = 4'b0001;
    repeat (10) @(posedge clock); #1;
    check("held_by_busy", start_count, sc);
    check("held_pending", pending, 4'b0001);
    push_frame(2'd0);
    busy_force = 1'b0;
    @(posedge clock); #1;
    check("start_after_busy", tx_start, 1'b1);
    check("start_after_busy_data", tx_data, 8'h30);
    wait_drain(3000);
    switch_debounced = 4'd0;
    repeat (3) @(posedge clock); #1;

    // Reset while waiting for the UART to acknowledge the ID byte
    switch_debounced = 4'b1000;
    sb.push_back('{data: 8'h33, gid: 2'd3, chk_gid: 1'b1});
    repeat (2) @(posedge clock); #1;
    check("pre_reset_start", tx_start, 1'b1);
    @(posedge clock); #1;
    check("in_ack_id", dut.state_r, ACK_ID);
    reset = 1'b0;
    #1;
    check("mid_reset_tx_start", tx_start, 1'b0);
    check("mid_reset_pending", pending, 4'h0);
    check("mid_reset_state", dut.state_r, IDLE);
    switch_debounced = 4'd0;
    repeat (3) @(posedge clock); #1;
    reset = 1'b1;
    sc = start_count;
    repeat (60) @(posedge clock); #1;
    check("no_start_after_reset", start_count, sc);
    check("idle_after_reset", dut.state_r, IDLE);

    // ID byte only when the newline is disabled
    switch2 = 4'b1000;
    sb2.push_back('{data: 8'h33, gid: 2'd3, chk_gid: 1'b1});
    repeat (80) @(posedge clock); #1;
    check("nl0_start_count", start_count2, 1);
    check("nl0_idle", dut2.state_r, IDLE);
    check("nl0_pending", pending2, 4'h0);
    check("nl0_grant_id", grant_id2, 2'd3);

    check("sb_empty", sb.size(), 0);
    check("sb2_empty", sb2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_tx_scheduler.md
Name: button_tx_scheduler

Overview:
Shares one UART transmitter among NUM_BUTTONS debounced push-button lines. Each debounced press is captured as a pending request. Requests are granted round-robin, and each grant is serialised to the UART as an ASCII identifier byte, optionally followed by a newline byte. The block sits between the per-button switch_debouncer instances and the UART TX block.

Parameters:
NUM_BUTTONS, 4, number of requesters (2..8)
BASE_CHAR, 8'h30, byte sent for button i is BASE_CHAR+i (modulo 256)
SEND_NEWLINE, 1, 1 = send NEWLINE_CHAR after the ID byte; 0 = ID byte only
NEWLINE_CHAR, 8'h0A, terminator byte

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low
switch_debounced  in  NUM_BUTTONS  level outputs of the debouncers, synchronous to clock
tx_busy  in  1  UART busy; rises 1..16 cycles after tx_start, falls when the stop bit completes
clear_overrun  in  1  synchronous clear for overrun
tx_start  out  1  one-cycle start pulse to the UART
tx_data  out  8  byte to transmit; stable from tx_start until tx_busy falls
pending  out  NUM_BUTTONS  queued requests
grant_id  out  $clog2(NUM_BUTTONS)  index of the button currently being served
overrun  out  NUM_BUTTONS  sticky: press arrived while the same bit was already pending

Behaviour:
Reset is reset (asynchronous, active-low) on clock. All outputs, the edge-detect history, the round-robin pointer and the FSM are forced to 0 / IDLE.

Edge detect:
- prev register holds the last value of switch_debounced.
- rise[i] = switch_debounced[i] & ~prev[i].

Pending and overrun:
- rise[i] sets pending[i] on the next edge.
- If pending[i] is already 1 when rise[i] occurs, set overrun[i].
- Grant clears pending[i]. If set and clear hit the same cycle, set wins (the press is queued again) and no overrun is flagged.
- clear_overrun zeroes overrun. A coincident new overrun wins.

Round-robin arbitration:
- Search starts at last_grant+1 and wraps modulo NUM_BUTTONS. First pending bit found wins.
- last_grant resets to NUM_BUTTONS-1, so button 0 has first priority after reset.

FSM states: IDLE, SEND_ID, ACK_ID, DONE_ID, SEND_NL, ACK_NL, DONE_NL.
- IDLE: if pending != 0 and tx_busy == 0, then on the same edge: latch grant_id and last_grant, set tx_data = BASE_CHAR+grant, clear that pending bit, pulse tx_start, go to ACK_ID. If tx_busy == 1, hold in IDLE.
- ACK_ID: wait for tx_busy == 1, then go to DONE_ID. tx_start is low here.
- DONE_ID: wait for tx_busy == 0. If SEND_NEWLINE, go to SEND_NL; otherwise go to IDLE.
- SEND_NL: set tx_data = NEWLINE_CHAR, pulse tx_start, go to ACK_NL.
- ACK_NL: wait for tx_busy == 1, then go to DONE_NL.
- DONE_NL: wait for tx_busy == 0, then go to IDLE.
- SEND_ID is reserved for a registered-output variant. The IDLE→ACK_ID path issues the ID start directly.

Timing:
- A rise sampled at cycle t gives pending=1 at t+1.
- In IDLE with tx_busy low, tx_start=1 at t+2, and pending cleared at t+2.
- tx_start is never high for two consecutive cycles.
- tx_start is never asserted while tx_busy == 1.

Other rules:
- grant_id holds its value until the next grant.
- Presses arriving during a transmission queue normally and never abort the current frame.
- Reset mid-frame returns to IDLE, drops tx_start, and loses all pending requests.

Decomposition:
- Shared package uart_pkg: FSM state encoding (localparam 3-bit), the byte-width constant 8, and the default NEWLINE_CHAR.
- One sub-module, rr_arbiter (parameter N; inputs req and last; outputs gnt_valid and gnt_idx), purely combinational.
- Edge detect, pending/overrun logic and the FSM stay in button_tx_scheduler.

Test Plan:
1. Reset, then raise button 2 for 50 cycles. UART model uses busy rise delay 2 and busy length 20. Expect: tx_start at t+2 with tx_data=8'h32, grant_id=2; then a second tx_start with 8'h0A after busy falls; pending returns to 0.
2. Raise buttons 0, 1 and 3 in the same cycle. Expect ID bytes in order 0x30, 0x31, 0x33, each followed by 0x0A; grant_id sequence 0, 1, 3.
3. With last_grant=1, press buttons 0 and 3 together. Expect button 3 (0x33) served before button 0 (wrap-around).
4. While button 1 is pending, toggle it low then high (second rise). Expect overrun[1]=1 and only one 0x31 frame. Pulse clear_overrun: expect overrun[1]=0.
5. Hold tx_busy=1 externally, then press button 0. Expect no tx_start until tx_busy drops, then 0x30 within 1 cycle. Separately, assert reset during ACK_ID: expect tx_start=0, pending=0, state IDLE, and no further start pulses.
6. Set SEND_NEWLINE=0 and press button 3. Expect exactly one tx_start with 0x33, then IDLE.
